fifo_rd_drain: RTL

Read-side drain stage placed directly downstream of the asynchronous FIFO in the `rd_clk` domain. It issues `rd_en` to the FIFO whenever data is available and local space exists, and captures the returned words into a 3-entry output buffer. It presents the words on a valid/ready stream with full single-word-per-cycle throughput and counts delivered words. `m_ready` never reaches `rd_en` combinationally.

---
 rtl/fifo_rd_drain.sv | 77 +++++++
 1 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain stage for an asynchronous FIFO (rd_clk domain).
// Pulls words out of the FIFO with credit-based rd_en and holds them in a
// 3-entry circular buffer, then presents them on a valid/ready stream.
// rd_en depends only on registered state, drain_en and fifo_Empty, so the
// consumer's m_ready never reaches the FIFO read port combinationally.
module fifo_rd_drain #(
    parameter int N = 8
) (
    input  logic         rd_clk,
    input  logic         rd_rst,
    input  logic         fifo_Empty,
    input  logic [N-1:0] rd_data,
    output logic         rd_en,
    input  logic         drain_en,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [1:0]   occupancy,
    output logic [15:0]  xfer_count
);

    logic [N-1:0] mem [0:2];
    logic [1:0]   wr_idx;
    logic [1:0]   rd_idx;
    logic         inflight;
    logic         pop;
    logic [2:0]   credit_used;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Credit check: buffered plus in-flight words must leave room for one more.
    // rd_rst gates rd_en so no read is requested while the FIFO pointer is held in reset.
    always_comb begin
        credit_used = {1'b0, occupancy} + {2'b00, inflight};
        rd_en       = rd_rst & drain_en & ~fifo_Empty & (credit_used < 3'd3);
    end

    // Stream side: head of buffer is presented whenever anything is held.
    always_comb begin
        m_valid = (occupancy != 2'd0);
        m_data  = mem[rd_idx];
        pop     = m_valid & m_ready;
    end

    // Buffer storage: capture the word returned by last cycle's read.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= '0;
        end else if (inflight) begin
            mem[wr_idx] <= rd_data;
            wr_idx      <= next_idx(wr_idx);
        end
    end

    // Control state: in-flight flag, read index, occupancy and delivered-word count.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            inflight   <= 1'b0;
            rd_idx     <= '0;
            occupancy  <= '0;
            xfer_count <= '0;
        end else begin
            inflight  <= rd_en;
            occupancy <= occupancy + {1'b0, inflight} - {1'b0, pop};
            if (pop) begin
                rd_idx     <= next_idx(rd_idx);
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

endmodule
